fp_result_collector: RTL

//  Downstream stage of the FP adder/subtractor top. Takes each result with the rready/rtaken

---
 rtl/fp_result_collector.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fp_result_collector.sv
// Result capture FSM, FWFT FIFO and special-result counters behind the FP adder.
// Counter logic is built only when FP_RES_STATS_EN is defined.
module fp_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rready,
  input  logic [31:0]                  rout,
  input  logic                         nan_in,
  input  logic                         inf_in,
  input  logic                         err_in,
  output logic                         rtaken,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic [2:0]                   out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         clr_cnt,
  output logic [CNT_W-1:0]             nan_cnt,
  output logic [CNT_W-1:0]             inf_cnt,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    WAIT_LOW
  } state_t;

  state_t state, state_n;

  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, push, pop;

  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_n = state;
    push    = 1'b0;
    rtaken  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rready && !full) begin
          push    = 1'b1;
          state_n = TAKE;
        end
      end
      TAKE: begin
        rtaken  = 1'b1;
        state_n = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!rready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {err_in, inf_in, nan_in, rout};
  end

  // Head is gated so the outputs read 0 whenever the FIFO is empty.
  assign out_data  = out_valid ? mem[rd_ptr][31:0]  : '0;
  assign out_flags = out_valid ? mem[rd_ptr][34:32] : '0;

`ifdef FP_RES_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             f
  );
    return (f && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
      err_cnt <= '0;
    end else if (push) begin
      nan_cnt <= sat_inc(nan_cnt, nan_in);
      inf_cnt <= sat_inc(inf_cnt, inf_in);
      err_cnt <= sat_inc(err_cnt, err_in);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign nan_cnt    = '0;
  assign inf_cnt    = '0;
  assign err_cnt    = '0;
`endif

endmodule
